// File: rtl/alu_exec_stage.sv
// Execute stage after the shifter: S1 captures operands, S2 holds the ALU result and flags.
// Valid/ready on both sides; the architectural status updates only when a load_status op retires.
module alu_exec_stage #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] ain,
    input  logic         asel,
    input  logic [W-1:0] sout,
    input  logic [1:0]   alu_op,
    input  logic         load_status,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [2:0]   c_flags,
    output logic [2:0]   status
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } alu_op_e;

    logic         s1_valid_q;
    logic [W-1:0] s1_a_q;
    logic [W-1:0] s1_b_q;
    alu_op_e      s1_op_q;
    logic         s1_ls_q;

    logic         s2_valid_q;
    logic [W-1:0] c_q;
    logic [2:0]   flags_q;
    logic         s2_ls_q;
    logic [2:0]   status_q;

    logic         adv_c;
    logic         retire_c;
    logic         xfer_c;
    logic [W-1:0] res_c;
    logic         v_c;
    logic [2:0]   flags_c;

    // Handshake: S1 may move on when S2 is empty or is draining this cycle.
    assign adv_c    = s1_valid_q && (!s2_valid_q || out_ready);
    assign retire_c = s2_valid_q && out_ready;
    assign in_ready = !reset && (!s1_valid_q || adv_c);
    assign xfer_c   = in_valid && in_ready;

    // ALU and flag generation on the S1 operands.
    always_comb begin
        res_c = '0;
        v_c   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_c = s1_a_q + s1_b_q;
                v_c   = (s1_a_q[W-1] == s1_b_q[W-1]) && (res_c[W-1] != s1_a_q[W-1]);
            end
            OP_SUB: begin
                res_c = s1_a_q + ~s1_b_q + W'(1);
                v_c   = (s1_a_q[W-1] != s1_b_q[W-1]) && (res_c[W-1] != s1_a_q[W-1]);
            end
            OP_AND:  res_c = s1_a_q & s1_b_q;
            OP_NOT:  res_c = ~s1_b_q;
            default: res_c = '0;
        endcase
        flags_c = {(res_c == '0), res_c[W-1], v_c};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s1_ls_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            flags_q    <= '0;
            s2_ls_q    <= 1'b0;
            status_q   <= '0;
        end else begin
            if (xfer_c) begin
                s1_a_q  <= asel ? '0 : ain;
                s1_b_q  <= sout;
                s1_op_q <= alu_op_e'(alu_op);
                s1_ls_q <= load_status;
            end
            if (xfer_c) begin
                s1_valid_q <= 1'b1;
            end else if (adv_c) begin
                s1_valid_q <= 1'b0;
            end

            if (adv_c) begin
                s2_valid_q <= 1'b1;
                c_q        <= res_c;
                flags_q    <= flags_c;
                s2_ls_q    <= s1_ls_q;
            end else if (retire_c) begin
                s2_valid_q <= 1'b0;
            end

            // Status takes the flags of the entry leaving S2, so it follows retire order.
            if (retire_c && s2_ls_q) begin
                status_q <= flags_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign c         = c_q;
    assign c_flags   = flags_q;
    assign status    = status_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: op results and flags, latency, backpressure, status gating, reset.
module tb_alu_exec_stage;

    localparam int unsigned W = 16;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] NOT = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ain;
    logic         asel;
    logic [W-1:0] sout;
    logic [1:0]   alu_op;
    logic         load_status;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic [2:0]   c_flags;
    logic [2:0]   status;

    int total = 0;
    int bad   = 0;

    alu_exec_stage #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ain         (ain),
        .asel        (asel),
        .sout        (sout),
        .alu_op      (alu_op),
        .load_status (load_status),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .c_flags     (c_flags),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Offer one op and return one time unit after the edge that accepts it.
    task automatic send(input logic [W-1:0] a, input logic as, input logic [W-1:0] b,
                        input logic [1:0] op, input logic ls);
        int n;
        n = 0;
        in_valid = 1'b1; ain = a; asel = as; sout = b; alu_op = op; load_status = ls;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Op result must be visible exactly one edge after acceptance (2-cycle latency).
    task automatic op_check(input string tag, input logic [W-1:0] a, input logic as,
                            input logic [W-1:0] b, input logic [1:0] op,
                            input logic [W-1:0] exp_c, input logic [2:0] exp_f);
        send(a, as, b, op, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_ov"}, 32'(out_valid), 32'(1));
        chk({tag, "_c"}, 32'(c), 32'(exp_c));
        chk({tag, "_f"}, 32'(c_flags), 32'(exp_f));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int nret;
        logic [W-1:0] got [4];

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        ain = '0; asel = 1'b0; sout = '0; alu_op = ADD; load_status = 1'b0;

        // Reset / idle
        @(posedge clk); #1;
        chk("rst_inrdy0", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        chk("rst_inrdy1", 32'(in_ready), 32'(0));
        chk("rst_ov", 32'(out_valid), 32'(0));
        chk("rst_c", 32'(c), 32'(0));
        chk("rst_f", 32'(c_flags), 32'(0));
        chk("rst_status", 32'(status), 32'(0));
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("rel_inrdy", 32'(in_ready), 32'(1));

        // Basic ops and overflow boundaries
        op_check("add",     16'h0001, 1'b0, 16'h0842, ADD, 16'h0843, 3'b000);
        op_check("and",     16'h8421, 1'b0, 16'h0842, AND, 16'h0000, 3'b100);
        op_check("not",     16'hFFFF, 1'b0, 16'h0F0F, NOT, 16'hF0F0, 3'b010);
        op_check("sub_ov",  16'h7FFF, 1'b0, 16'hFFFF, SUB, 16'h8000, 3'b011);
        op_check("add_ov",  16'h7FFF, 1'b0, 16'h0001, ADD, 16'h8000, 3'b011);
        op_check("sub_z",   16'h0005, 1'b0, 16'h0005, SUB, 16'h0000, 3'b100);
        op_check("asel",    16'hFFFF, 1'b1, 16'h1234, ADD, 16'h1234, 3'b000);
        op_check("sub_nov", 16'h8000, 1'b0, 16'h0001, SUB, 16'h7FFF, 3'b001);
        @(posedge clk); #1;
        chk("basic_drain", 32'(out_valid), 32'(0));
        chk("basic_status", 32'(status), 32'(0));

        // Status gating: visible only at retire of load_status ops
        send(16'h0003, 1'b0, 16'h0003, SUB, 1'b1);
        @(posedge clk); #1;
        chk("st1_c", 32'(c), 32'(16'h0000));
        chk("st1_not_at_load", 32'(status), 32'(3'b000));
        @(posedge clk); #1;
        chk("st1_retired", 32'(status), 32'(3'b100));
        send(16'h7FFF, 1'b0, 16'h0001, ADD, 1'b0);
        @(posedge clk); #1;
        chk("st2_c", 32'(c), 32'(16'h8000));
        @(posedge clk); #1;
        chk("st2_hold", 32'(status), 32'(3'b100));
        send(16'h0001, 1'b0, 16'h0002, SUB, 1'b1);
        @(posedge clk); #1;
        chk("st3_c", 32'(c), 32'(16'hFFFF));
        @(posedge clk); #1;
        chk("st3_status", 32'(status), 32'(3'b010));

        // Backpressure: 4 ops, out_ready low for 5 cycles
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 4);
            ain = 16'(idx + 1); sout = 16'(idx + 1); alu_op = ADD; asel = 1'b0; load_status = 1'b0;
            #1;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (cyc >= 1) begin
                chk("bp_c", 32'(c), 32'(16'h0002));
                chk("bp_ov", 32'(out_valid), 32'(1));
            end
        end
        ain = 16'(idx + 1); sout = 16'(idx + 1);
        #1;
        chk("bp_accepts", 32'(idx), 32'(2));
        chk("bp_inrdy", 32'(in_ready), 32'(0));
        chk("bp_status", 32'(status), 32'(3'b010));

        out_ready = 1'b1;
        nret = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (idx < 4);
            ain = 16'(idx + 1); sout = 16'(idx + 1);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                if (nret < 4) got[nret] = c;
                nret++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_all_acc", 32'(idx), 32'(4));
        chk("bp_nret", 32'(nret), 32'(4));
        for (int k = 0; k < 4; k++) chk("bp_order", 32'(got[k]), 32'(2 * (k + 1)));
        chk("bp_empty", 32'(out_valid), 32'(0));

        // Reset mid-operation with both stages full
        out_ready = 1'b0;
        send(16'h0003, 1'b0, 16'h0003, SUB, 1'b1);
        send(16'h0004, 1'b0, 16'h0004, SUB, 1'b1);
        #1;
        chk("mid_full_inrdy", 32'(in_ready), 32'(0));
        chk("mid_full_ov", 32'(out_valid), 32'(1));
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        chk("mid_rst_inrdy", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_ov", 32'(out_valid), 32'(0));
        chk("mid_status", 32'(status), 32'(3'b000));
        chk("mid_c", 32'(c), 32'(0));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("mid_no_retire", 32'(out_valid), 32'(0));
        end
        chk("mid_status_hold", 32'(status), 32'(3'b000));
        op_check("post_rst", 16'h0010, 1'b0, 16'h0020, ADD, 16'h0030, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
